// File: rtl/aes_link_pkg.sv
// Shared definitions for the UART -> AES block link.
// Used by the block assembler, the input FIFO and the AES core wrapper.
package aes_link_pkg;

    localparam int BYTE_W          = 8;
    localparam int BYTES_PER_BLOCK = 16;
    localparam int BLOCK_W         = BYTE_W * BYTES_PER_BLOCK;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } asm_state_t;

endpackage

// File: rtl/rx_gap_timer.sv
// Inter-byte gap counter for the block assembler.
// expire is combinational so the owner can act on the same cycle.
module rx_gap_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] count_r;

    assign expire = run && (count_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // Gap count register; restarts on a byte or after an expiry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear || expire) begin
            count_r <= {CNT_W{1'b0}};
        end else if (run) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/rx_block_assembler.sv
// Packs UART bytes into one AES block and strobes it into the input FIFO.
// Stalled partial blocks are discarded after TIMEOUT_CYCLES idle cycles.
module rx_block_assembler
    import aes_link_pkg::*;
#(
    parameter int BYTES_PER_BLOCK = 16,
    parameter int TIMEOUT_CYCLES  = 100000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    input  logic                         fifo_full,
    output logic [8*BYTES_PER_BLOCK-1:0] dout,
    output logic                         ready,
    output logic                         busy,
    output logic [4:0]                   byte_count,
    output logic                         drop_err,
    output logic                         timeout_err
);

    localparam int BW = 8 * BYTES_PER_BLOCK;

    asm_state_t      state_r, state_s;
    logic [BW-1:0]   shreg_r, shreg_s;
    logic [BW-1:0]   dout_r, dout_s;
    logic [4:0]      count_r, count_s;
    logic            ready_r, ready_s;
    logic            drop_r, drop_s;
    logic            tmo_r, tmo_s;
    logic            expire_s;
    logic            gap_run_s;
    logic [BW-1:0]   shifted_s;

    assign gap_run_s = (state_r == COLLECT) && !rx_valid;
    assign shifted_s = {shreg_r[BW-9:0], rx_data};

    rx_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (rx_valid),
        .run    (gap_run_s),
        .expire (expire_s)
    );

    // Next-state, shift register and output pulse decode
    always_comb begin
        state_s = state_r;
        shreg_s = shreg_r;
        dout_s  = dout_r;
        count_s = count_r;
        ready_s = 1'b0;
        drop_s  = 1'b0;
        tmo_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (rx_valid) begin
                    shreg_s = shifted_s;
                    count_s = 5'd1;
                    state_s = COLLECT;
                end else begin
                    state_s = IDLE;
                end
            end
            COLLECT: begin
                if (rx_valid) begin
                    shreg_s = shifted_s;
                    if (count_r == 5'(BYTES_PER_BLOCK - 1)) begin
                        // fifo_full is judged in the same cycle as the last byte
                        if (!fifo_full) begin
                            dout_s  = shifted_s;
                            ready_s = 1'b1;
                        end else begin
                            drop_s = 1'b1;
                        end
                        count_s = 5'd0;
                        state_s = IDLE;
                    end else begin
                        count_s = count_r + 5'd1;
                    end
                end else if (expire_s) begin
                    tmo_s   = 1'b1;
                    count_s = 5'd0;
                    state_s = IDLE;
                end else begin
                    state_s = COLLECT;
                end
            end
            default: begin
                count_s = 5'd0;
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            shreg_r <= {BW{1'b0}};
            dout_r  <= {BW{1'b0}};
            count_r <= 5'd0;
            ready_r <= 1'b0;
            drop_r  <= 1'b0;
            tmo_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            shreg_r <= shreg_s;
            dout_r  <= dout_s;
            count_r <= count_s;
            ready_r <= ready_s;
            drop_r  <= drop_s;
            tmo_r   <= tmo_s;
        end
    end

    assign dout        = dout_r;
    assign ready       = ready_r;
    assign busy        = (state_r == COLLECT);
    assign byte_count  = count_r;
    assign drop_err    = drop_r;
    assign timeout_err = tmo_r;

endmodule

// File: tb/tb_rx_block_assembler.sv
// Randomised and directed bench for rx_block_assembler against a queue-based
// model of the block/timeout/drop rules, compared on every falling edge.
module tb_rx_block_assembler;

    localparam int NB  = 16;
    localparam int TMO = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         fifo_full;
    logic [127:0] dout;
    logic         ready, busy, drop_err, timeout_err;
    logic [4:0]   byte_count;

    int tests  = 0;
    int errors = 0;

    rx_block_assembler #(.BYTES_PER_BLOCK(NB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .fifo_full(fifo_full), .dout(dout), .ready(ready), .busy(busy),
        .byte_count(byte_count), .drop_err(drop_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Model state: bytes of the current partial block and idle cycles since the last byte
    logic [7:0]   q[$];
    int           idle_cnt;
    logic [127:0] m_dout;
    logic         m_ready, m_drop, m_tmo;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: what the outputs must show after each edge
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            idle_cnt = 0;
            m_dout   = '0;
            m_ready  = 1'b0;
            m_drop   = 1'b0;
            m_tmo    = 1'b0;
        end else begin
            m_ready = 1'b0;
            m_drop  = 1'b0;
            m_tmo   = 1'b0;
            if (rx_valid) begin
                q.push_back(rx_data);
                idle_cnt = 0;
                if (q.size() == NB) begin
                    if (!fifo_full) begin
                        for (int i = 0; i < NB; i++) m_dout[127-8*i -: 8] = q[i];
                        m_ready = 1'b1;
                    end else begin
                        m_drop = 1'b1;
                    end
                    q.delete();
                end
            end else if (q.size() > 0) begin
                idle_cnt++;
                if (idle_cnt == TMO) begin
                    m_tmo = 1'b1;
                    q.delete();
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        check("dout", dout, m_dout);
        check("ready", 128'(ready), 128'(m_ready));
        check("drop_err", 128'(drop_err), 128'(m_drop));
        check("timeout_err", 128'(timeout_err), 128'(m_tmo));
        check("busy", 128'(busy), 128'(q.size() > 0));
        check("byte_count", 128'(byte_count), 128'(q.size()));
    end

    task automatic send(input logic [7:0] b, input logic full);
        rx_data   = b;
        rx_valid  = 1'b1;
        fifo_full = full;
        @(posedge clk); #1;
        rx_valid  = 1'b0;
        fifo_full = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_block(input logic [7:0] base, input int gap, input logic full_last);
        for (int i = 0; i < NB; i++) begin
            send(base + 8'(i), (i == NB - 1) ? full_last : 1'b0);
            if (i != NB - 1 && gap > 0) idle(gap);
        end
    endtask

    logic [127:0] saved;
    int           k;

    initial begin
        reset = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_dout", dout, 128'h0);
        check("reset_busy", 128'(busy), 128'h0);
        reset = 1'b1;
        idle(2);

        // Consecutive block
        send_block(8'h00, 0, 1'b0);
        check("blk0_ready", 128'(ready), 128'h1);
        check("blk0_dout", dout, 128'h000102030405060708090A0B0C0D0E0F);
        check("blk0_model", m_dout, 128'h000102030405060708090A0B0C0D0E0F);
        check("blk0_busy", 128'(busy), 128'h0);
        idle(1);
        check("blk0_pulse", 128'(ready), 128'h0);

        // Spaced bytes just under the timeout
        send_block(8'hA0, TMO - 2, 1'b0);
        check("spaced_dout", dout, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
        idle(3);

        // Timeout after 5 bytes
        for (int i = 0; i < 5; i++) send(8'hC0 + 8'(i), 1'b0);
        k = 0;
        while (!timeout_err && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("tmo_latency", 128'(k), 128'd8);
        check("tmo_count", 128'(byte_count), 128'h0);
        check("tmo_dout", dout, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
        send_block(8'h10, 0, 1'b0);
        check("post_tmo_dout", dout, 128'h101112131415161718191A1B1C1D1E1F);

        // FIFO full on the last byte
        send_block(8'h20, 0, 1'b1);
        check("drop_pulse", 128'(drop_err), 128'h1);
        check("drop_noready", 128'(ready), 128'h0);
        check("drop_dout", dout, 128'h101112131415161718191A1B1C1D1E1F);
        send_block(8'h30, 0, 1'b0);
        check("after_drop_dout", dout, 128'h303132333435363738393A3B3C3D3E3F);

        // Back-to-back blocks
        send_block(8'h40, 0, 1'b0);
        check("b2b_first", dout, 128'h404142434445464748494A4B4C4D4E4F);
        saved = dout;
        for (int i = 0; i < NB; i++) begin
            send(8'h50 + 8'(i), 1'b0);
            if (i < NB - 1) check("b2b_hold", dout, saved);
        end
        check("b2b_second", dout, 128'h505152535455565758595A5B5C5D5E5F);

        // Mid-block asynchronous reset
        for (int i = 0; i < 10; i++) send(8'hE0 + 8'(i), 1'b0);
        #2 reset = 1'b0;
        #1;
        check("arst_dout", dout, 128'h0);
        check("arst_count", 128'(byte_count), 128'h0);
        check("arst_busy", 128'(busy), 128'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        send_block(8'h60, 0, 1'b0);
        check("post_rst_dout", dout, 128'h606162636465666768696A6B6C6D6E6F);

        // Random traffic with gaps, FIFO-full and occasional resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                #2 reset = 1'b0;
                @(posedge clk); #1;
                reset = 1'b1;
            end else if ($urandom_range(0, 19) == 0) begin
                idle($urandom_range(TMO - 2, TMO + 2));
            end else if ($urandom_range(0, 2) != 0) begin
                send(8'($urandom), ($urandom_range(0, 3) == 0));
            end else begin
                idle(1);
            end
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
